// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size codes and
// the controller state encoding.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: extracts and extends load data from a RAM word
// and merges sub-word store data into it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[8*lane +: 8];
  assign half_sel = rword[16*lane[1] +: 16];

  always_comb begin
    rdata  = rword;
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        rdata  = {{24{byte_sel[7] & ~uns}}, byte_sel};
        merged = rword;
        merged[8*lane +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata  = {{16{half_sel[15] & ~uns}}, half_sel};
        merged = rword;
        merged[16*lane[1] +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for the 32-bit data RAM. Sub-word stores go through a
// read-modify-write; all RAM pins decode from the state register and latched request.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_cs,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the request is ready only in IDLE, the response is valid only in RESP.
  state_t            state, state_nx;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q, uns_q, err_q;
  logic [31:0]       wdata_q, rword;
  logic [31:0]       ext_data, merged;
  logic              accept, err_in;

  assign accept = (state == IDLE) && req_valid;

  assign err_in = (req_size == 2'b11)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
               || (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (err_in)                                state_nx = RESP;
        else if (!req_we || (req_size != SZ_WORD)) state_nx = RD;
        else                                       state_nx = WR;
      end
      RD:   state_nx = we_q ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rword   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W+1:0];
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= err_in;
        wdata_q <= req_wdata;
      end
      if (state == RD) rword <= mem_data_out;
    end
  end

  dmem_lane_align u_align (
    .rword  (rword),
    .wdata  (wdata_q),
    .lane   (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .rdata  (ext_data),
    .merged (merged)
  );

  // The merge result equals wdata for word stores, so WR always drives it.
  assign mem_cs       = (state == RD) || (state == WR);
  assign mem_read_en  = (state == RD);
  assign mem_write_en = (state == WR);
  assign mem_addr     = mem_cs ? addr_q[ADDR_W+1:2] : '0;
  assign mem_data_in  = (state == WR) ? merged : '0;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = ((state == RESP) && !err_q && !we_q) ? ext_data : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a behavioural RAM, directed scenarios from the test
// plan, and a shadow-model random phase, with a response scoreboard.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_cs, mem_read_en, mem_write_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_in, mem_data_out;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  logic [31:0] ram [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] sh [0:7];

  always #5 clk = ~clk;

  assign mem_data_out = mem_read_en ? ram[mem_addr] : 'z;
  always @(posedge clk) begin
    if (mem_cs && mem_write_en) ram[mem_addr] <= mem_data_in;
    else if (bd_we)             ram[bd_addr]  <= bd_data;
  end

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_cs(mem_cs),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lane);
    logic [31:0] s;
    s = w >> (8 * lane);
    case (sz)
      2'b00:   return uns ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
      2'b01:   return uns ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] mask;
    mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * lane);
    return (w & ~mask) | ((wd << (8 * lane)) & mask);
  endfunction

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                         input logic exp_rdph, input logic exp_wrph, input int hold,
                         input string name);
    int lat;
    logic saw_cs, saw_rd, saw_wr, order_ok, addr_ok;
    logic [32:0] exp;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; saw_cs = 0; saw_rd = 0; saw_wr = 0; order_ok = 1; addr_ok = 1;
    while (lat < 20) begin
      lat++;
      if (resp_valid === 1'b1) break;
      if (mem_cs === 1'b1) saw_cs = 1;
      if (mem_read_en === 1'b1) begin
        saw_rd = 1;
        if (saw_wr) order_ok = 0;
        if (mem_addr !== addr[11:2]) addr_ok = 0;
      end
      if (mem_write_en === 1'b1) begin
        saw_wr = 1;
        if (mem_addr !== addr[11:2]) addr_ok = 0;
      end
      if (mem_read_en === 1'b1 && mem_write_en === 1'b1) order_ok = 0;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (resp_valid !== 1'b1) begin
      n_err++; $display("FAIL %s timeout: resp_valid=%b after %0d cycles, want 1", name, resp_valid, lat);
    end
    n_vec++;
    if (resp_err !== exp[32]) begin
      n_err++; $display("FAIL %s resp_err: got %b want %b", name, resp_err, exp[32]);
    end
    n_vec++;
    if (resp_rdata !== exp[31:0]) begin
      n_err++; $display("FAIL %s resp_rdata: got %h want %h", name, resp_rdata, exp[31:0]);
    end
    n_vec++;
    if (lat != exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if ({saw_cs, saw_rd, saw_wr} !== {exp_rdph | exp_wrph, exp_rdph, exp_wrph}) begin
      n_err++; $display("FAIL %s ram phases {cs,rd,wr}: got %b want %b", name,
                        {saw_cs, saw_rd, saw_wr}, {exp_rdph | exp_wrph, exp_rdph, exp_wrph});
    end
    n_vec++;
    if (!(order_ok && addr_ok)) begin
      n_err++; $display("FAIL %s ram sequencing: order_ok=%b addr_ok=%b want 1 1", name, order_ok, addr_ok);
    end
    for (int i = 0; i < hold; i++) begin
      // a competing request while the response is stalled must be ignored
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
      n_vec++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== exp[31:0] || resp_err !== exp[32]) begin
        n_err++;
        $display("FAIL %s hold cycle %0d: valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                 name, i, resp_valid, req_ready, resp_rdata, resp_err, exp[31:0], exp[32]);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s release: resp_valid=%b req_ready=%b want 0 1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_vec++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL reset resp flags: valid=%b err=%b want 0 0", resp_valid, resp_err);
    end
    n_vec++;
    if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
    n_vec++;
    if ({mem_cs, mem_read_en, mem_write_en} !== 3'b000) begin
      n_err++; $display("FAIL reset mem enables: got %b want 000", {mem_cs, mem_read_en, mem_write_en});
    end
    n_vec++;
    if (mem_addr !== 10'h0 || mem_data_in !== 32'h0) begin
      n_err++; $display("FAIL reset mem bus: addr=%h data=%h want 0 0", mem_addr, mem_data_in);
    end
  endtask

  task automatic test_word_store_load;
    run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0, 1'b1, 0, "word_store");
    n_vec++;
    if (ram[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_store ram: got %h want deadbeef", ram[4]); end
    run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b1, 1'b0, 0, "word_load");
  endtask

  task automatic test_byte_merge;
    bd_write(10'd4, 32'h11223344);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_00AB, 1'b0, 32'h0, 3, 1'b1, 1'b1, 0, "byte_merge");
    n_vec++;
    if (ram[4] !== 32'h11AB3344) begin n_err++; $display("FAIL byte_merge ram: got %h want 11ab3344", ram[4]); end
  endtask

  task automatic test_extension;
    bd_write(10'd4, 32'h8070F0E0);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFF0, 2, 1'b1, 1'b0, 0, "byte_signed");
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1'b0, 32'h000000F0, 2, 1'b1, 1'b0, 0, "byte_unsigned");
    run_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF8070, 2, 1'b1, 1'b0, 0, "half_signed");
  endtask

  task automatic test_errors;
    run_req(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 0, "err_misaligned");
    run_req(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 0, "err_range");
    run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h5555, 1'b1, 32'h0, 1, 1'b0, 1'b0, 0, "err_size");
    n_vec++;
    if (ram[4] !== 32'h8070F0E0) begin n_err++; $display("FAIL err_size ram touched: got %h want 8070f0e0", ram[4]); end
  endtask

  task automatic test_backpressure;
    run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8070F0E0, 2, 1'b1, 1'b0, 5, "backpressure");
    n_vec++;
    if (ram[4] !== 32'h8070F0E0) begin n_err++; $display("FAIL backpressure ram touched: got %h want 8070f0e0", ram[4]); end
  endtask

  task automatic test_random;
    logic [1:0] sz, lane;
    logic we, uns;
    int w;
    logic [31:0] wd, exp_rd;
    for (int i = 0; i < 8; i++) begin
      sh[i] = $urandom;
      bd_write(i[9:0], sh[i]);
    end
    for (int i = 0; i < 24; i++) begin
      w    = $urandom_range(0, 7);
      sz   = 2'($urandom_range(0, 2));
      lane = (sz == SZ_WORD) ? 2'd0 : (sz == SZ_HALF) ? {1'($urandom_range(0, 1)), 1'b0}
                                                      : 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (we) begin
        sh[w] = ref_merge(sh[w], wd, sz, lane);
        run_req(1'b1, sz, uns, 32'(w * 4) + 32'(lane), wd, 1'b0, 32'h0,
                (sz == SZ_WORD) ? 2 : 3, sz != SZ_WORD, 1'b1, 0, "rand_store");
      end else begin
        exp_rd = ref_load(sh[w], sz, uns, lane);
        run_req(1'b0, sz, uns, 32'(w * 4) + 32'(lane), wd, 1'b0, exp_rd, 2, 1'b1, 1'b0, 0, "rand_load");
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (ram[i] !== sh[i]) begin n_err++; $display("FAIL rand ram word %0d: got %h want %h", i, ram[i], sh[i]); end
    end
  endtask

  task automatic test_reset_mid_store;
    int n;
    bd_write(10'd4, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_write_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (mem_write_en !== 1'b1) begin n_err++; $display("FAIL mid_reset timeout: mem_write_en=%b want 1", mem_write_en); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_write_en !== 1'b0 || mem_cs !== 1'b0) begin
      n_err++; $display("FAIL mid_reset enables: we=%b cs=%b want 0 0", mem_write_en, mem_cs);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ram[4] !== 32'hCAFEF00D) begin n_err++; $display("FAIL mid_reset ram: got %h want cafef00d", ram[4]); end
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset after: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_word_store_load;
    test_byte_merge;
    test_extension;
    test_errors;
    test_backpressure;
    test_random;
    test_reset_mid_store;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller between the core's load/store stage and the 32x1024 data RAM.
- Accepts byte-addressed load/store requests over a valid/ready handshake and checks alignment and range.
- Sub-word stores use a read-modify-write sequence.
- Loads return sign- or zero-extended data over a valid/ready response channel.
- Drives the RAM's cs/read_en/write_en/addr/data_in pins; samples its data_out.

Parameters:
ADDR_W, 10, RAM word-address width (depth = 2**ADDR_W words)
BASE_ADDR, 32'h0000_0000, byte base of the RAM window; must be aligned to 4*2**ADDR_W

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal-size or out-of-range access
mem_cs  output  1  RAM chip select
mem_read_en  output  1  RAM read enable
mem_write_en  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM word address
mem_data_in  output  32  RAM write data
mem_data_out  input  32  RAM read data (tri-stated when not read-enabled)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- State: FSM states IDLE, RD, WR, RESP, encoded in a registered state; mem_* outputs are decoded from the state register and the latched request only.
- Reset values:
  - State = IDLE.
  - req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_cs, mem_read_en and mem_write_en = 0; mem_addr = 0; mem_data_in = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, size, we, unsigned and wdata, then evaluate the error check:
    - err if size = 11;
    - err if half and addr[0] = 1;
    - err if word and addr[1:0] != 0;
    - err if addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2].
  - Next state:
    - err -> RESP with resp_err = 1; no RAM access.
    - Load, or store of byte/half -> RD.
    - Word store -> WR.
- RD:
  - mem_cs = 1, mem_read_en = 1, mem_write_en = 0, mem_addr = addr[ADDR_W+1:2].
  - At the clock edge, capture mem_data_out into rword.
  - Load -> RESP with resp_rdata = extract(rword).
  - Sub-word store -> WR.
- WR:
  - mem_cs = 1, mem_write_en = 1, mem_read_en = 0.
  - mem_data_in = wdata for word stores, merge(rword, wdata) otherwise.
  - The RAM commits at the clock edge -> RESP.
- RESP:
  - resp_valid = 1 and req_ready = 0; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready -> IDLE. A new request is accepted no earlier than the following cycle.
- Latency, from the accept edge to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Byte lanes are little-endian; lane = addr[1:0].
- Extract:
  - Byte: rword[8*lane +: 8].
  - Half: rword[16*addr[1] +: 16].
  - Sign-extend unless req_unsigned. Word returns as-is.
- Merge:
  - Replace only the addressed byte or half of rword with wdata[7:0] or wdata[15:0].
  - All other bits are preserved.
- mem_read_en and mem_write_en are never both 1.
- req_valid held high while req_ready = 0 is ignored; the producer must hold the request until the handshake completes.
- Reset mid-operation: state goes to IDLE immediately and the enables drop combinationally, so a WR cut before its edge performs no write.
- rword is don't-care after reset; no response is issued for an aborted request.

Decomposition:
- Shared package dmem_pkg holds:
  - size codes SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - FSM state encoding.
- One combinational sub-module, dmem_lane_align, takes rword, wdata, lane, size and unsigned, and produces the extracted load data and the merged store word.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x10, resp_err = 0; load word from 0x10 -> resp_rdata = 0xDEADBEEF, 2 cycles after accept.
- Byte merge: RAM word 0x10 = 0x11223344; store byte 0xAB to 0x12 -> word becomes 0x11AB3344; check that RD precedes WR and the store takes 3 cycles.
- Extension, with word = 0x8070F0E0:
  - Signed byte load at 0x11 -> 0xFFFFFFF0.
  - Unsigned byte load at 0x11 -> 0x000000F0.
  - Signed half load at 0x12 -> 0xFFFF8070.
- Errors:
  - Half load at 0x13 -> resp_err = 1 and resp_rdata = 0, with no mem_cs pulse.
  - Word access at BASE_ADDR + 0x1000 -> err.
  - Size 11 -> err.
- Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0; accept on release.
- Reset mid-store: assert rst_n = 0 during WR before the edge -> mem_write_en drops immediately and the RAM word is unchanged; after release req_ready = 1 and resp_valid = 0.
